mshr_ctrl: RTL and testbench
============================

// Module: mshr_ctrl
// PURPOSE
//  Allocates, issues and retires miss-status holding registers (MSHRs) for the data cache.
//  On a cache miss it hands the load/store queue an MSHR index (the lsq mshr_wr_idx input).
//  It merges misses to a line that is already outstanding and round-robins line requests to memory.
//  On a fill it pulses mshr_fin/mshr_fin_idx so the load/store queue can wake waiting entries.
// PARAMETERS
//  N_MSHR      8   number of MSHR entries; must equal 2**IDX_W
//  IDX_W       3   MSHR index width; matches the lsq mshr index ports
//  ADDR_W      32  byte address width
//  LINE_OFF_W  4   line offset bits; a line is 16 B
// PORTS
//  clk            in   1                   clock, rising edge
//  rst            in   1                   asynchronous reset, active-low
//  miss_valid     in   1                   cache presents a miss this cycle
//  miss_addr      in   ADDR_W              byte address of the miss
//  miss_ready     out  1                   miss accepted this cycle (combinational)
//  miss_idx       out  IDX_W               MSHR index assigned to the accepted miss (combinational)
//  miss_merged    out  1                   accepted miss joined an existing entry
//  mem_req_valid  out  1                   line request to memory
//  mem_req_addr   out  ADDR_W              line address; offset bits are zero
//  mem_req_id     out  IDX_W               MSHR index tagging the request
//  mem_req_ready  in   1                   memory accepts the request
//  mem_resp_valid in   1                   fill returned
//  mem_resp_id    in   IDX_W               MSHR index of the fill
//  mshr_fin       out  1                   one-cycle retire pulse to the lsq
//  mshr_fin_idx   out  IDX_W               index retired
//  mshr_full      out  1                   no FREE entry
//  proto_err      out  1                   sticky: fill arrived for an entry that is not ISSUED
// BEHAVIOUR
//  Per-entry state (2b): FREE=0, PEND=1, ISSUED=2. Each entry also holds line address tag[ADDR_W-1:LINE_OFF_W].
//  Reset (rst=0, asynchronous):
//   - all entries FREE; round-robin pointer = 0.
//   - mshr_fin=0, mshr_fin_idx=0, proto_err=0.
//   - combinational outputs then give miss_ready=1 and mem_req_valid=0.
//   - Reset mid-operation drops all outstanding requests; memory is also reset.
//  Merge hit: a non-FREE entry whose tag equals miss_addr line and which is not being retired this cycle.
//   At most one entry can hit, because allocation never duplicates a live tag.
//  Acceptance: miss_ready = merge_hit | !mshr_full.
//   - On merge hit: miss_idx = the hitting entry, miss_merged=1, no state change.
//   - Otherwise: miss_idx = the lowest FREE index; that entry becomes PEND with its tag at the next edge.
//  Issue:
//   - mem_req_valid = any entry PEND.
//   - mem_req_id = first PEND at or after the rr pointer, wrapping at N_MSHR-1 to 0.
//   - mem_req_addr = {tag,0}.
//   - On valid&ready: that entry becomes ISSUED and the pointer moves to id+1 (mod N_MSHR).
//   - Valid stays asserted until the handshake completes. The id may change only when a new PEND entry is added at a higher priority.
//  Retire:
//   - mem_resp_valid with mem_resp_id in ISSUED: the entry becomes FREE at the next edge.
//   - mshr_fin=1 and mshr_fin_idx=mem_resp_id are registered, so the pulse appears 1 cycle after the response, for exactly 1 cycle.
//   - A response for a FREE or PEND entry changes no state, gives no pulse, and sets proto_err.
//  Simultaneous events:
//   - Retiring entry: does not count as merge-hit or FREE this cycle. A same-line miss allocates a new entry.
//   - Allocate + issue + retire in one cycle: all apply, because they always touch distinct entries.
//   - A response may arrive in the same cycle as the issue handshake of another id.
//   - Full: when mshr_full and no merge hit, miss_ready=0 and the cache must hold its miss. An entry freed by a retire is usable the following cycle.
//  Widths: tags compare on ADDR_W-LINE_OFF_W bits. The rr pointer is IDX_W bits and wraps naturally.
// STRUCTURE
//  Shared package cache_pkg:
//   - MSHR state localparams FREE/PEND/ISSUED.
//   - N_MSHR, IDX_W, LINE_OFF_W.
//  Submodule rr_arb #(N) : request vector + pointer -> grant index + any.
//   - Used for issue selection.
//   - The lowest-free search is a fixed-priority encoder inline.
// TESTING
//  1. Reset: after rst low then high, mshr_full=0, miss_ready=1, mem_req_valid=0, mshr_fin=0.
//  2. Miss 0x1000 -> miss_idx=0, merged=0. Next cycle mem_req_valid=1, addr=0x1000, id=0. Ready=1.
//     Then resp id=0 -> mshr_fin=1, idx=0 one cycle later, for one cycle only.
//  3. Misses 0x1000 then 0x1008 -> the second gets miss_idx=0, merged=1, and only one mem request is issued.
//  4. Eight misses to distinct lines, mem_req_ready=0 -> idx 0..7, mshr_full=1.
//     A ninth distinct miss -> miss_ready=0.
//     Resp id=3 -> next cycle a new miss gets idx 3.
//  5. PEND entries 1,2,5 with ptr=2 and ready held 1 -> ids issued 2,5,1.
//  6. Resp id=6 while entry 6 is FREE -> no fin pulse, proto_err=1 and stays 1 until reset.
//     Also: resp for entry 0 with a same-line miss in the same cycle -> new entry allocated, merged=0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants for the data-cache miss handling logic.
//  - MSHR geometry (entry count, index width) and address split.
//  - Per-entry MSHR state encoding (FREE / PEND / ISSUED).
package cache_pkg;

  localparam int N_MSHR     = 8;
  localparam int IDX_W      = 3;
  localparam int ADDR_W     = 32;
  localparam int LINE_OFF_W = 4;
  localparam int TAG_W      = ADDR_W - LINE_OFF_W;

  typedef logic [1:0] mshr_st_t;

  localparam mshr_st_t FREE   = 2'd0;
  localparam mshr_st_t PEND   = 2'd1;
  localparam mshr_st_t ISSUED = 2'd2;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter.
//  Picks the first asserted request at or after ptr, wrapping from N-1 back to 0.
//  N must be a power of two so the IDX_W-bit candidate index wraps naturally.
// Ports:
//  req      in   N       request vector
//  ptr      in   IDX_W   highest-priority position
//  gnt_idx  out  IDX_W   granted index (equals ptr when nothing requests)
//  any      out  1       at least one request asserted
module rr_arb #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt_idx = ptr;
    cand    = ptr;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        gnt_idx = cand;
        found   = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mshr_ctrl.sv
// MSHR controller for the data cache.
//  Allocates an MSHR per missing line (merging misses to a line already
//  outstanding), round-robins line requests to memory and retires entries on
//  fill with a registered one-cycle pulse to the load/store queue.
// Ports:
//  clk, rst                      clock; asynchronous active-low reset
//  miss_valid/addr               miss from the cache
//  miss_ready/idx/merged         acceptance, assigned MSHR, merge indication
//  mem_req_valid/addr/id/ready   line request to memory
//  mem_resp_valid/id             fill from memory
//  mshr_fin/mshr_fin_idx         retire pulse to the lsq
//  mshr_full                     no FREE entry
//  proto_err                     sticky: fill for an entry that was not ISSUED
module mshr_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic [IDX_W-1:0]  miss_idx,
  output logic              miss_merged,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [IDX_W-1:0]  mem_req_id,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [IDX_W-1:0]  mem_resp_id,
  output logic              mshr_fin,
  output logic [IDX_W-1:0]  mshr_fin_idx,
  output logic              mshr_full,
  output logic              proto_err
);

  mshr_st_t         state_q [N_MSHR];
  mshr_st_t         state_d [N_MSHR];
  logic [TAG_W-1:0] tag_q   [N_MSHR];
  logic [TAG_W-1:0] tag_d   [N_MSHR];
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             fin_q, fin_d;
  logic [IDX_W-1:0] fin_idx_q, fin_idx_d;
  logic             proto_err_q, proto_err_d;

  logic [TAG_W-1:0]  miss_line;
  logic [N_MSHR-1:0] pend_vec, free_vec, hit_vec;
  logic [IDX_W-1:0]  merge_idx, free_idx;
  logic              merge_hit, retire_ok, alloc, issue_fire;

  assign miss_line = miss_addr[ADDR_W-1:LINE_OFF_W];
  assign retire_ok = mem_resp_valid && (state_q[mem_resp_id] == ISSUED);

  // The entry being retired this cycle is neither a merge target nor free,
  // so a same-line miss in that cycle allocates a fresh entry.
  always_comb begin
    pend_vec  = '0;
    free_vec  = '0;
    hit_vec   = '0;
    merge_idx = '0;
    free_idx  = '0;
    for (int i = 0; i < N_MSHR; i++) begin
      pend_vec[i] = (state_q[i] == PEND);
      free_vec[i] = (state_q[i] == FREE);
      hit_vec[i]  = (state_q[i] != FREE) && (tag_q[i] == miss_line) &&
                    !(retire_ok && (mem_resp_id == IDX_W'(i)));
    end
    // Descending scan leaves the lowest matching index; at most one hit exists.
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      if (free_vec[i]) free_idx  = IDX_W'(i);
      if (hit_vec[i])  merge_idx = IDX_W'(i);
    end
  end

  assign merge_hit   = |hit_vec;
  assign mshr_full   = ~|free_vec;
  assign miss_ready  = merge_hit | ~mshr_full;
  assign miss_idx    = merge_hit ? merge_idx : free_idx;
  assign miss_merged = miss_valid & merge_hit;
  assign alloc       = miss_valid & ~merge_hit & ~mshr_full;

  rr_arb #(.N(N_MSHR), .IDX_W(IDX_W)) u_issue_arb (
    .req     (pend_vec),
    .ptr     (rr_ptr_q),
    .gnt_idx (mem_req_id),
    .any     (mem_req_valid)
  );

  assign mem_req_addr = {tag_q[mem_req_id], {LINE_OFF_W{1'b0}}};
  assign issue_fire   = mem_req_valid & mem_req_ready;

  // Allocate, issue and retire always target distinct entries (FREE, PEND,
  // ISSUED respectively), so applying them in sequence never conflicts.
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    rr_ptr_d    = rr_ptr_q;
    if (alloc) begin
      state_d[free_idx] = PEND;
      tag_d[free_idx]   = miss_line;
    end
    if (issue_fire) begin
      state_d[mem_req_id] = ISSUED;
      rr_ptr_d            = mem_req_id + IDX_W'(1);
    end
    if (retire_ok) state_d[mem_resp_id] = FREE;
    fin_d       = retire_ok;
    fin_idx_d   = retire_ok ? mem_resp_id : fin_idx_q;
    proto_err_d = proto_err_q | (mem_resp_valid & ~retire_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_MSHR; i++) state_q[i] <= FREE;
      rr_ptr_q    <= '0;
      fin_q       <= 1'b0;
      fin_idx_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      fin_q       <= fin_d;
      fin_idx_q   <= fin_idx_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Tags are only meaningful while the entry is non-FREE; no reset needed.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign mshr_fin     = fin_q;
  assign mshr_fin_idx = fin_idx_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_mshr_ctrl.sv
module tb_mshr_ctrl;
  import cache_pkg::*;

  logic              clk;
  logic              rst;
  logic              miss_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic [IDX_W-1:0]  miss_idx;
  logic              miss_merged;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [IDX_W-1:0]  mem_req_id;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [IDX_W-1:0]  mem_resp_id;
  logic              mshr_fin;
  logic [IDX_W-1:0]  mshr_fin_idx;
  logic              mshr_full;
  logic              proto_err;

  mshr_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .miss_valid     (miss_valid),
    .miss_addr      (miss_addr),
    .miss_ready     (miss_ready),
    .miss_idx       (miss_idx),
    .miss_merged    (miss_merged),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_id     (mem_req_id),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_id    (mem_resp_id),
    .mshr_fin       (mshr_fin),
    .mshr_fin_idx   (mshr_fin_idx),
    .mshr_full      (mshr_full),
    .proto_err      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        mv;
    logic [31:0] addr;
    logic        rdy;
    logic        rv;
    logic [2:0]  rid;
    logic        e_ready;
    logic [2:0]  e_idx;
    logic        e_merged;
    logic        e_reqv;
    logic [31:0] e_addr;
    logic [2:0]  e_id;
    logic        e_fin;
    logic [2:0]  e_fin_idx;
    logic        e_full;
    logic        e_perr;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic mv, input logic [31:0] addr, input logic rdy,
                              input logic rv, input logic [2:0] rid, input logic e_ready,
                              input logic [2:0] e_idx, input logic e_merged, input logic e_reqv,
                              input logic [31:0] e_addr, input logic [2:0] e_id, input logic e_fin,
                              input logic [2:0] e_fin_idx, input logic e_full, input logic e_perr);
    vec_t v;
    v.mv = mv; v.addr = addr; v.rdy = rdy; v.rv = rv; v.rid = rid;
    v.e_ready = e_ready; v.e_idx = e_idx; v.e_merged = e_merged; v.e_reqv = e_reqv;
    v.e_addr = e_addr; v.e_id = e_id; v.e_fin = e_fin; v.e_fin_idx = e_fin_idx;
    v.e_full = e_full; v.e_perr = e_perr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after a falling edge, then settle 1 ns.
  task automatic drv(input logic mv, input logic [31:0] addr, input logic rdy,
                     input logic rv, input logic [2:0] rid);
    @(negedge clk);
    miss_valid     = mv;
    miss_addr      = addr;
    mem_req_ready  = rdy;
    mem_resp_valid = rv;
    mem_resp_id    = rid;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    miss_valid = 1'b0; miss_addr = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_id = '0;
    #1;
    chk("rst_async_reqv", mem_req_valid, 0);
    chk("rst_async_full", mshr_full, 0);
    chk("rst_async_ready", miss_ready, 1);
    chk("rst_async_fin", mshr_fin, 0);
    chk("rst_async_perr", proto_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b0;
    miss_valid = 1'b0; miss_addr = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_id = '0;

    vt[0]  = mk(0, 32'h0,    0, 0, 0, 1, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0);
    vt[1]  = mk(1, 32'h1000, 0, 0, 0, 1, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0);
    vt[2]  = mk(1, 32'h1008, 0, 0, 0, 1, 0, 1, 1, 32'h1000, 0, 0, 0, 0, 0);
    vt[3]  = mk(0, 32'h0,    1, 0, 0, 1, 0, 0, 1, 32'h1000, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 32'h0,    1, 0, 0, 1, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0);
    vt[5]  = mk(0, 32'h0,    0, 1, 0, 1, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0);
    vt[6]  = mk(0, 32'h0,    0, 0, 0, 1, 0, 0, 0, 32'h0,    0, 1, 0, 0, 0);
    vt[7]  = mk(0, 32'h0,    0, 0, 0, 1, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0);
    vt[8]  = mk(0, 32'h0,    0, 1, 6, 1, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0);
    vt[9]  = mk(0, 32'h0,    0, 0, 0, 1, 0, 0, 0, 32'h0,    0, 0, 0, 0, 1);
    vt[10] = mk(1, 32'h2000, 0, 0, 0, 1, 0, 0, 0, 32'h0,    0, 0, 0, 0, 1);
    vt[11] = mk(0, 32'h0,    1, 0, 0, 1, 0, 0, 1, 32'h2000, 0, 0, 0, 0, 1);
    vt[12] = mk(1, 32'h2004, 0, 1, 0, 1, 1, 0, 0, 32'h0,    0, 0, 0, 0, 1);
    vt[13] = mk(0, 32'h0,    0, 0, 0, 1, 0, 0, 1, 32'h2000, 1, 1, 0, 0, 1);
    vt[14] = mk(0, 32'h0,    1, 0, 0, 1, 0, 0, 1, 32'h2000, 1, 0, 0, 0, 1);
    vt[15] = mk(0, 32'h0,    0, 1, 1, 1, 0, 0, 0, 32'h0,    0, 0, 0, 0, 1);
    vt[16] = mk(0, 32'h0,    0, 0, 0, 1, 0, 0, 0, 32'h0,    0, 1, 1, 0, 1);
    vt[17] = mk(0, 32'h0,    0, 0, 0, 1, 0, 0, 0, 32'h0,    0, 0, 0, 0, 1);

    // Power-on reset and post-reset state
    do_reset();
    drv(0, 0, 0, 0, 0);
    chk("reset_full", mshr_full, 0);
    chk("reset_ready", miss_ready, 1);
    chk("reset_reqv", mem_req_valid, 0);
    chk("reset_fin", mshr_fin, 0);
    chk("reset_fin_idx", mshr_fin_idx, 0);
    chk("reset_perr", proto_err, 0);

    // Table: single miss, merge, issue, retire pulse, bad response, retire+same-line miss
    for (int i = 0; i < 18; i++) begin
      v = vt[i];
      drv(v.mv, v.addr, v.rdy, v.rv, v.rid);
      chk($sformatf("v%0d_ready", i), miss_ready, v.e_ready);
      if (v.mv) begin
        chk($sformatf("v%0d_idx", i), miss_idx, v.e_idx);
        chk($sformatf("v%0d_merged", i), miss_merged, v.e_merged);
      end
      chk($sformatf("v%0d_reqv", i), mem_req_valid, v.e_reqv);
      if (v.e_reqv) begin
        chk($sformatf("v%0d_req_addr", i), mem_req_addr, v.e_addr);
        chk($sformatf("v%0d_req_id", i), mem_req_id, v.e_id);
      end
      chk($sformatf("v%0d_fin", i), mshr_fin, v.e_fin);
      if (v.e_fin) chk($sformatf("v%0d_fin_idx", i), mshr_fin_idx, v.e_fin_idx);
      chk($sformatf("v%0d_full", i), mshr_full, v.e_full);
      chk($sformatf("v%0d_perr", i), proto_err, v.e_perr);
    end

    // Fill all entries, refuse a ninth miss, free one entry and reuse it
    do_reset();
    drv(0, 0, 0, 0, 0);
    chk("full_seq_perr_cleared", proto_err, 0);
    for (int i = 0; i < 8; i++) begin
      drv(1, 32'h10000 + 32'(i * 16), 0, 0, 0);
      chk($sformatf("fill%0d_ready", i), miss_ready, 1);
      chk($sformatf("fill%0d_idx", i), miss_idx, i);
      chk($sformatf("fill%0d_merged", i), miss_merged, 0);
    end
    drv(1, 32'h20000, 0, 0, 0);
    chk("ninth_full", mshr_full, 1);
    chk("ninth_ready", miss_ready, 0);
    chk("ninth_reqv", mem_req_valid, 1);
    chk("ninth_req_id", mem_req_id, 0);
    for (int k = 0; k < 4; k++) begin
      drv(1, 32'h20000, 1, 0, 0);
      chk($sformatf("full_issue%0d_id", k), mem_req_id, k);
      chk($sformatf("full_issue%0d_addr", k), mem_req_addr, 32'h10000 + 32'(k * 16));
      chk($sformatf("full_issue%0d_ready", k), miss_ready, 0);
    end
    drv(1, 32'h20000, 0, 1, 3);
    chk("retire_cycle_ready", miss_ready, 0);
    drv(1, 32'h20000, 0, 0, 0);
    chk("reuse_ready", miss_ready, 1);
    chk("reuse_idx", miss_idx, 3);
    chk("reuse_merged", miss_merged, 0);
    chk("reuse_fin", mshr_fin, 1);
    chk("reuse_fin_idx", mshr_fin_idx, 3);
    drv(0, 0, 0, 0, 0);
    chk("reuse_fin_off", mshr_fin, 0);
    chk("reuse_full_again", mshr_full, 1);
    chk("full_seq_perr", proto_err, 0);

    // Reset mid-operation drops everything
    do_reset();
    drv(0, 0, 0, 0, 0);
    chk("midrst_reqv", mem_req_valid, 0);
    chk("midrst_full", mshr_full, 0);
    chk("midrst_fin", mshr_fin, 0);

    // Round-robin: move pointer to 3, then to 2 with PEND {1,2,5}
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'h30000 + 32'(i * 16), 0, 0, 0);
      chk($sformatf("rr_a%0d_idx", i), miss_idx, i);
    end
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 1, 0, 0);
      chk($sformatf("rr_b%0d_id", k), mem_req_id, k);
    end
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 0, 1, 3'(k));
    end
    for (int i = 0; i < 5; i++) begin
      drv(1, 32'h40000 + 32'(i * 16), 0, 0, 0);
      chk($sformatf("rr_c%0d_idx", i), miss_idx, i);
    end
    begin
      logic [2:0] exp_ids [4];
      exp_ids[0] = 3; exp_ids[1] = 4; exp_ids[2] = 0; exp_ids[3] = 1;
      for (int k = 0; k < 4; k++) begin
        drv(0, 0, 1, 0, 0);
        chk($sformatf("rr_d%0d_id", k), mem_req_id, exp_ids[k]);
      end
    end
    drv(0, 0, 0, 1, 1);
    drv(1, 32'h50000, 0, 0, 0);
    chk("rr_e_idx", miss_idx, 1);
    chk("rr_e_merged", miss_merged, 0);
    drv(1, 32'h50010, 0, 0, 0);
    chk("rr_f_idx", miss_idx, 5);
    chk("rr_f_req_id", mem_req_id, 2);
    begin
      logic [2:0]  exp_ids [3];
      logic [31:0] exp_addr [3];
      exp_ids[0] = 2; exp_addr[0] = 32'h40020;
      exp_ids[1] = 5; exp_addr[1] = 32'h50010;
      exp_ids[2] = 1; exp_addr[2] = 32'h50000;
      for (int k = 0; k < 3; k++) begin
        drv(0, 0, 1, 0, 0);
        chk($sformatf("rr_g%0d_reqv", k), mem_req_valid, 1);
        chk($sformatf("rr_g%0d_id", k), mem_req_id, exp_ids[k]);
        chk($sformatf("rr_g%0d_addr", k), mem_req_addr, exp_addr[k]);
      end
    end
    drv(0, 0, 1, 0, 0);
    chk("rr_done_reqv", mem_req_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
